video_timing_gen: RTL and testbench

Parametrised video timing generator, successor to the fixed-polarity free-running timing block. It drives hsync, vsync and active video plus pixel coordinates for the display pipeline from the pixel clock. Additions over the previous generation: configurable counter width and sync polarity, registered outputs, start/stop at frame boundaries, line/frame strobes, a frame counter, and an optional early pixel-request stream so framebuffer or FFT-plot readers can prefetch.

---
 rtl/video_timing_pkg.sv | 38 +++
 rtl/video_timing_gen_if.sv | 62 ++++++
 rtl/video_delay_line.sv | 43 ++++
 rtl/video_timing_gen.sv | 186 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared definitions for the video timing generator:
//   - vtg_state_e    : sequencer states (IDLE / RUN / DRAIN)
//   - vtg_mode_t     : timing preset record (active + blanking segments)
//   - MODE_480X800   : 480x800 portrait panel (default build)
//   - MODE_640X480_60: VESA 640x480@60
//   - POL_*          : sync polarity constants
//   - seg_total      : sums the four segments of one axis
package video_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vtg_state_e;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vtg_mode_t;

    localparam vtg_mode_t MODE_480X800    = '{480, 24, 48, 48, 800, 3, 5, 25};
    localparam vtg_mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33};

    function automatic int seg_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
// Bundles the control input and all timing outputs of video_timing_gen.
//   master modport : generator side (drives timing, reads enable)
//   slave  modport : display-pipeline side
// Signals:
//   enable                 run request into the generator
//   running                generator not idle
//   hsync/vsync/active     timing at configured polarity
//   pixel_x/pixel_y        coordinates of the current output position
//   line_start/frame_start one-cycle strobes
//   frame_count            frame counter
//   state_dbg              sequencer state, for observation only
//   req/req_x/req_y        early request stream, present only when
//                          VTG_LOOKAHEAD_EN is defined
// The request stream is valid-only: req marks a pixel that will be shown
// LOOKAHEAD cycles later; there is no ready, the consumer must keep up.
interface video_timing_gen_if
    import video_timing_pkg::*;
#(
    parameter int CW = 11
) ();
    logic          enable;
    logic          running;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;
    logic [15:0]   frame_count;
    vtg_state_e    state_dbg;
`ifdef VTG_LOOKAHEAD_EN
    logic          req;
    logic [CW-1:0] req_x;
    logic [CW-1:0] req_y;

    modport master (
        input  enable,
        output running, hsync, vsync, active, pixel_x, pixel_y,
        output line_start, frame_start, frame_count, state_dbg,
        output req, req_x, req_y
    );
    modport slave (
        output enable,
        input  running, hsync, vsync, active, pixel_x, pixel_y,
        input  line_start, frame_start, frame_count, state_dbg,
        input  req, req_x, req_y
    );
`else
    modport master (
        input  enable,
        output running, hsync, vsync, active, pixel_x, pixel_y,
        output line_start, frame_start, frame_count, state_dbg
    );
    modport slave (
        output enable,
        input  running, hsync, vsync, active, pixel_x, pixel_y,
        input  line_start, frame_start, frame_count, state_dbg
    );
`endif
endinterface

// File: rtl/video_delay_line.sv
// video_delay_line
// Fixed-depth shift register with asynchronous clear to a configurable
// value, so a delayed bundle of signals comes out of reset at its idle
// levels rather than all-zero.
// Ports:
//   clk, rst : clock, asynchronous active-high clear
//   din      : WIDTH-bit input
//   dout     : din delayed by DEPTH cycles (DEPTH >= 1)
module video_delay_line #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= CLR_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Parametrised video timing generator. A frame-level sequencer
// (IDLE/RUN/DRAIN) gates free-running h/v position counters; the
// position is decoded into sync/active/strobe/coordinate signals and
// registered. Stopping is only ever done at the last position of a frame.
// Ports:
//   clk_pixel : pixel clock
//   rst       : asynchronous active-high reset
//   vif       : video_timing_gen_if.master (enable in, timing out)
// Optional feature macro: VTG_LOOKAHEAD_EN
//   defined   : decoded position is published on req/req_x/req_y one
//               cycle after the counters, and the main outputs follow
//               through a LOOKAHEAD-deep delay line.
//   undefined : main outputs are one register stage after the counters;
//               LOOKAHEAD has no effect.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE      = MODE_480X800.h_active,
    parameter int   H_FRONT_PORCH = MODE_480X800.h_fp,
    parameter int   H_SYNC        = MODE_480X800.h_sync,
    parameter int   H_BACK_PORCH  = MODE_480X800.h_bp,
    parameter int   V_ACTIVE      = MODE_480X800.v_active,
    parameter int   V_FRONT_PORCH = MODE_480X800.v_fp,
    parameter int   V_SYNC        = MODE_480X800.v_sync,
    parameter int   V_BACK_PORCH  = MODE_480X800.v_bp,
    parameter int   CW            = 11,
    parameter logic HSYNC_POL     = POL_ACTIVE_LOW,
    parameter logic VSYNC_POL     = POL_ACTIVE_LOW,
    parameter int   LOOKAHEAD     = 2
) (
    input  logic               clk_pixel,
    input  logic               rst,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = seg_total(H_ACTIVE, H_FRONT_PORCH, H_SYNC, H_BACK_PORCH);
    localparam int V_TOTAL = seg_total(V_ACTIVE, V_FRONT_PORCH, V_SYNC, V_BACK_PORCH);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);

    // One decoded output position.
    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          active;
        logic          line_start;
        logic          frame_start;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } beat_t;

    localparam beat_t IDLE_BEAT = '{
        hsync:       ~HSYNC_POL,
        vsync:       ~VSYNC_POL,
        active:      1'b0,
        line_start:  1'b0,
        frame_start: 1'b0,
        x:           '0,
        y:           '0
    };

    vtg_state_e    state_q, state_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    beat_t         beat_q, beat_d;
    beat_t         out_beat;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          at_last;

    assign at_last = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    // Sequencer. A stop request seen on the final position of a frame
    // goes straight to IDLE; entering DRAIN there would emit a whole
    // extra frame before stopping.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (vif.enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!vif.enable) state_d = at_last ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (vif.enable)   state_d = ST_RUN;
                else if (at_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Position counters: parked at (0,0) while idle so the first
    // position after a start is always the frame origin.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (state_q == ST_IDLE) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end else begin
            h_cnt_d = h_cnt_q + CW'(1);
        end
    end

    // Decode of the current position. The counters also read (0,0) in
    // IDLE, so decoding is suppressed there to keep strobes quiet.
    always_comb begin
        beat_d = IDLE_BEAT;
        if (state_q != ST_IDLE) begin
            beat_d.hsync       = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            beat_d.vsync       = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            beat_d.active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            beat_d.line_start  = (h_cnt_q == '0);
            beat_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
            beat_d.x           = h_cnt_q;
            beat_d.y           = v_cnt_q;
        end
    end

    // Counts frame_start as it leaves the block, so the count moves the
    // cycle after the strobe is seen downstream.
    always_comb begin
        frame_count_d = frame_count_q;
        if (out_beat.frame_start) frame_count_d = frame_count_q + 16'd1;
    end

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            beat_q        <= IDLE_BEAT;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            beat_q        <= beat_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef VTG_LOOKAHEAD_EN
    logic [$bits(beat_t)-1:0] dly_out;

    video_delay_line #(
        .WIDTH   ($bits(beat_t)),
        .DEPTH   (LOOKAHEAD),
        .CLR_VAL (IDLE_BEAT)
    ) u_delay (
        .clk  (clk_pixel),
        .rst  (rst),
        .din  (beat_q),
        .dout (dly_out)
    );

    assign out_beat  = beat_t'(dly_out);
    assign vif.req   = beat_q.active;
    assign vif.req_x = beat_q.x;
    assign vif.req_y = beat_q.y;
`else
    assign out_beat = beat_q;
`endif

    assign vif.running     = (state_q != ST_IDLE);
    assign vif.state_dbg   = state_q;
    assign vif.hsync       = out_beat.hsync;
    assign vif.vsync       = out_beat.vsync;
    assign vif.active      = out_beat.active;
    assign vif.pixel_x     = out_beat.x;
    assign vif.pixel_y     = out_beat.y;
    assign vif.line_start  = out_beat.line_start;
    assign vif.frame_start = out_beat.frame_start;
    assign vif.frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int CW  = 6;
    localparam int HA  = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA  = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int LA  = 2;
    localparam int HT  = HA + HFP + HS + HBP;   // 16
    localparam int VT  = VA + VFP + VS + VBP;   // 8
    localparam int FT  = HT * VT;               // 128
`ifdef VTG_LOOKAHEAD_EN
    localparam int LAT = LA;
`else
    localparam int LAT = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(CW)) if0 ();
    video_timing_gen_if #(.CW(CW)) if1 ();
    assign if0.enable = en;
    assign if1.enable = en;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP),
        .CW(CW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOOKAHEAD(LA)
    ) dut0 (
        .clk_pixel (clk),
        .rst       (rst),
        .vif       (if0)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP),
        .CW(CW), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .LOOKAHEAD(LA)
    ) dut1 (
        .clk_pixel (clk),
        .rst       (rst),
        .vif       (if1)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [7:0]  exp_q[$];     // {running, frame position} per cycle
    bit          m_run;
    int          m_pos;
    logic [15:0] exp_fc;
    bit          rec_fs = 1'b0;
    int          fs_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a frame is a run of FT positions; once started it
    // always finishes, and the next frame follows only if enable is high
    // on the last position. Outputs show position p one cycle after the
    // counters hold p, plus LAT cycles when lookahead is built in.
    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        exp_fc = 16'd0;
        exp_q.delete();
        repeat (LAT + 3) exp_q.push_back(8'h00);
    endtask

    task automatic model_step(input bit e);
        if (!m_run) begin
            if (e) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FT - 1) begin
            m_pos = 0;
            if (!e) m_run = 1'b0;
        end else begin
            m_pos = m_pos + 1;
        end
        exp_q.push_back({m_run, 7'(m_pos)});
        if (exp_q.size() > LAT + 3) void'(exp_q.pop_front());
    endtask

    task automatic check_cycle();
        logic [7:0] e;
        bit r;
        int p, x, y;
        bit hs_on, vs_on, e_act, e_ls, e_fs;
        e = exp_q[exp_q.size() - 2 - LAT];
        r = e[7];
        p = int'(e[6:0]);
        x = p % HT;
        y = p / HT;
        hs_on = r && (x >= HA + HFP) && (x < HA + HFP + HS);
        vs_on = r && (y >= VA + VFP) && (y < VA + VFP + VS);
        e_act = r && (x < HA) && (y < VA);
        e_ls  = r && (x == 0);
        e_fs  = r && (p == 0);
        chk("running",     if0.running,     m_run);
        chk("hsync",       if0.hsync,       hs_on ? 0 : 1);
        chk("vsync",       if0.vsync,       vs_on ? 0 : 1);
        chk("active",      if0.active,      e_act);
        chk("line_start",  if0.line_start,  e_ls);
        chk("frame_start", if0.frame_start, e_fs);
        chk("pixel_x",     if0.pixel_x,     r ? x : 0);
        chk("pixel_y",     if0.pixel_y,     r ? y : 0);
        chk("frame_count", if0.frame_count, exp_fc);
        chk("pol1_hsync",  if1.hsync,       hs_on ? 1 : 0);
        chk("pol1_active", if1.active,      e_act);
`ifdef VTG_LOOKAHEAD_EN
        begin
            logic [7:0] q;
            int qp, qx, qy;
            q  = exp_q[exp_q.size() - 2];
            qp = int'(q[6:0]);
            qx = qp % HT;
            qy = qp / HT;
            chk("req",   if0.req,   q[7] && (qx < HA) && (qy < VA));
            chk("req_x", if0.req_x, q[7] ? qx : 0);
            chk("req_y", if0.req_y, q[7] ? qy : 0);
        end
`endif
        if (e_fs) exp_fc = exp_fc + 16'd1;
        if (rec_fs && if0.frame_start === 1'b1) fs_cyc.push_back(cyc);
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step(en);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_running"},     if0.running,     0);
        chk({tag, "_hsync"},       if0.hsync,       1);
        chk({tag, "_vsync"},       if0.vsync,       1);
        chk({tag, "_active"},      if0.active,      0);
        chk({tag, "_pixel_x"},     if0.pixel_x,     0);
        chk({tag, "_pixel_y"},     if0.pixel_y,     0);
        chk({tag, "_line_start"},  if0.line_start,  0);
        chk({tag, "_frame_start"}, if0.frame_start, 0);
        chk({tag, "_frame_count"}, if0.frame_count, 0);
        chk({tag, "_pol1_hsync"},  if1.hsync,       0);
`ifdef VTG_LOOKAHEAD_EN
        chk({tag, "_req"},   if0.req,   0);
        chk({tag, "_req_x"}, if0.req_x, 0);
        chk({tag, "_req_y"}, if0.req_y, 0);
`endif
    endtask

    // ---------------- directed phase table ----------------
    typedef struct {
        bit en;
        int ticks;
        bit exp_running;
        int exp_fc;
    } phase_t;

    phase_t phases[6];

    initial begin
        phases[0] = '{1'b1, 300, 1'b1, 3};  // three frames started
        phases[1] = '{1'b0, 200, 1'b0, 3};  // drain to frame end, stop
        phases[2] = '{1'b1,  10, 1'b1, 4};  // restart
        phases[3] = '{1'b0,  20, 1'b1, 4};  // drop mid-frame ...
        phases[4] = '{1'b1, 300, 1'b1, 6};  // ... re-raise before frame end
        phases[5] = '{1'b0, 300, 1'b0, 6};  // final stop

        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_values("rst_hold");
        rst = 1'b0;
        repeat (3) tick();

        // Start latency, then async reset in the middle of active line 2.
        en = 1'b1;
        for (int t = 1; t <= LAT + 37; t++) begin
            tick();
            if (t == 1) chk("start_running", if0.running, 1);
            if (t == 1 + LAT) chk("start_fs_early", if0.frame_start, 0);
            if (t == 2 + LAT) begin
                chk("start_fs",     if0.frame_start, 1);
                chk("start_ls",     if0.line_start,  1);
                chk("start_active", if0.active,      1);
                chk("start_x",      if0.pixel_x,     0);
                chk("start_y",      if0.pixel_y,     0);
                chk("start_pol1_active", if1.active, 1);
            end
`ifdef VTG_LOOKAHEAD_EN
            if (t == 1) chk("req_early", if0.req, 0);
            if (t == 2) begin
                chk("req_first",   if0.req,   1);
                chk("req_first_x", if0.req_x, 0);
                chk("req_first_y", if0.req_y, 0);
            end
`endif
        end
        chk("line2_active", if0.active,      1);
        chk("line2_y",      if0.pixel_y,     2);
        chk("line2_fc",     if0.frame_count, 1);
        #2 rst = 1'b1;
        #1 chk_reset_values("rst_async");
        @(posedge clk);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        model_reset();

        // Table-driven phases.
        rec_fs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            en = phases[i].en;
            repeat (phases[i].ticks) tick();
            chk($sformatf("phase%0d_running", i), if0.running,     phases[i].exp_running);
            chk($sformatf("phase%0d_fc", i),      if0.frame_count, phases[i].exp_fc);
        end
        rec_fs = 1'b0;

        // Frame starts inside one uninterrupted run are exactly one frame
        // apart; the one after the stop/restart is later than that.
        chk("fs_seen", fs_cyc.size(), 6);
        for (int i = 1; i < fs_cyc.size(); i++) begin
            if (i == 3) chk("fs_gap_restart", (fs_cyc[i] - fs_cyc[i-1]) > FT, 1);
            else        chk($sformatf("fs_gap%0d", i), fs_cyc[i] - fs_cyc[i-1], FT);
        end

        // Randomised enable activity against the model.
        for (int s = 0; s < 30; s++) begin
            en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 200)) tick();
        end
        en = 1'b0;
        repeat (FT + LAT + 5) tick();
        chk("final_idle", if0.running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout @cyc %0d: got no finish want finish", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
